// File: rtl/conv2d_kxk_stream.sv
// Streaming KxK "valid" 2D convolution: K-1 line buffers, KxK window, serial weight load, saturated output.
// Optional build macro CONV_RELU_EN zeroes negative results ahead of the output register.
module conv2d_kxk_stream #(
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int X_BW   = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 20,
  parameter int O_BW   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_w_valid,
  input  logic signed [W_BW-1:0] i_w,
  output logic                   o_w_ready,
  input  logic                   i_sof,
  input  logic                   i_x_valid,
  input  logic signed [X_BW-1:0] i_x,
  output logic                   o_y_valid,
  output logic signed [O_BW-1:0] o_y
);

  localparam int NW  = K * K;
  localparam int PW  = X_BW + W_BW;
  localparam int WIW = $clog2(NW);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(K);

  localparam logic [WIW-1:0] W_LAST        = WIW'(NW - 1);
  localparam logic [WIW-1:0] W_SECOND      = WIW'(1);
  localparam logic [CW-1:0]  COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  COL_FIRST_RES = CW'(K - 1);
  localparam logic [CW-1:0]  COL_ONE       = CW'(1);
  localparam logic [RW-1:0]  ROW_LAST      = RW'(K - 1);
  localparam logic [RW-1:0]  ROW_ONE       = RW'(1);

  localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                   state_reg;
  logic [WIW-1:0]           w_idx_reg;
  logic [CW-1:0]            col_reg;
  logic [RW-1:0]            row_reg;

  logic [WIW-1:0]           w_slot;
  logic                     run_reload;
  logic                     accept;
  logic [CW-1:0]            pix_col;
  logic [RW-1:0]            pix_row;
  logic [CW-1:0]            col_next;
  logic [RW-1:0]            row_next;
  logic [CW-1:0]            col_d;
  logic [RW-1:0]            row_d;
  logic [CW-1:0]            rd_addr;
  logic                     win_done;

  logic signed [W_BW-1:0]   weight   [NW];
  logic signed [X_BW-1:0]   lb_rd    [K-1];
  logic signed [X_BW-1:0]   col_in   [K];
  logic signed [X_BW-1:0]   win_reg  [K][K];
  logic signed [ACC_BW-1:0] prod_ext [NW];
  logic signed [ACC_BW-1:0] sum_d;

  logic                     done_reg;
  logic                     acc_valid_reg;
  logic signed [ACC_BW-1:0] acc_reg;
  logic signed [O_BW-1:0]   sat_d;
  logic signed [O_BW-1:0]   y_d;

  // ---------------------------------------------------------------- weight FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_EMPTY;
      w_idx_reg <= '0;
      o_w_ready <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (i_w_valid) begin
            w_idx_reg <= W_SECOND;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_w_valid) begin
            if (w_idx_reg == W_LAST) begin
              w_idx_reg <= '0;
              state_reg <= ST_RUN;
              o_w_ready <= 1'b1;
            end else begin
              w_idx_reg <= w_idx_reg + W_SECOND;
            end
          end
        end
        ST_RUN: begin
          if (i_w_valid) begin
            w_idx_reg <= W_SECOND;
            state_reg <= ST_LOAD;
            o_w_ready <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          w_idx_reg <= '0;
          o_w_ready <= 1'b0;
        end
      endcase
    end
  end

  // A weight strobe outside LOAD always restarts the sequence at w[0].
  assign w_slot = (state_reg == ST_LOAD) ? w_idx_reg : '0;

  genvar gi;
  for (gi = 0; gi < NW; gi++) begin : g_weight
    logic signed [W_BW-1:0] w_reg;
    always_ff @(posedge i_clk) begin
      if (i_w_valid && (w_slot == WIW'(gi))) begin
        w_reg <= i_w;
      end
    end
    assign weight[gi] = w_reg;
  end

  // ---------------------------------------------------------------- pixel counters
  assign run_reload = (state_reg == ST_RUN) && i_w_valid;
  assign accept     = (state_reg == ST_RUN) && i_x_valid && !i_w_valid;
  assign pix_col    = i_sof ? '0 : col_reg;
  assign pix_row    = i_sof ? '0 : row_reg;
  assign col_next   = (pix_col == COL_LAST) ? '0 : pix_col + COL_ONE;
  assign row_next   = ((pix_col == COL_LAST) && (pix_row != ROW_LAST)) ? pix_row + ROW_ONE : pix_row;
  assign win_done   = accept && (pix_row == ROW_LAST) && (pix_col >= COL_FIRST_RES);

  always_comb begin
    col_d = col_reg;
    row_d = row_reg;
    if (run_reload) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      col_d = col_next;
      row_d = row_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_d;
      row_reg <= row_d;
    end
  end

  // Line buffers read one cycle ahead at the column the next pixel will occupy,
  // so the registered read is ready when that pixel arrives.
  assign rd_addr = i_rst_n ? col_d : '0;

  for (gi = 0; gi < K - 1; gi++) begin : g_line
    logic signed [X_BW-1:0] lb_mem [IMG_W];
    logic signed [X_BW-1:0] rd_reg;
    logic signed [X_BW-1:0] wr_data;
    if (gi == 0) begin : g_head
      assign wr_data = i_x;
    end else begin : g_tail
      assign wr_data = lb_rd[gi-1];
    end
    always_ff @(posedge i_clk) begin
      if (accept) begin
        lb_mem[pix_col] <= wr_data;
      end
      rd_reg <= lb_mem[rd_addr];
    end
    assign lb_rd[gi] = rd_reg;
  end

  // Window row 0 is the oldest image row, column K-1 the newest pixel.
  for (gi = 0; gi < K; gi++) begin : g_col_in
    if (gi == K - 1) begin : g_new
      assign col_in[gi] = i_x;
    end else begin : g_old
      assign col_in[gi] = lb_rd[K-2-gi];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][K-1] <= col_in[r];
      end
    end
  end

  // ---------------------------------------------------------------- MAC and output
  for (gi = 0; gi < NW; gi++) begin : g_mac
    logic signed [PW-1:0] prod;
    assign prod         = PW'(win_reg[gi / K][gi % K]) * PW'(weight[gi]);
    assign prod_ext[gi] = {{(ACC_BW-PW){prod[PW-1]}}, prod};
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NW; i++) begin
      sum_d = sum_d + prod_ext[i];
    end
  end

  always_comb begin
    if (acc_reg > SAT_MAX) begin
      sat_d = SAT_MAX[O_BW-1:0];
    end else if (acc_reg < SAT_MIN) begin
      sat_d = SAT_MIN[O_BW-1:0];
    end else begin
      sat_d = acc_reg[O_BW-1:0];
    end
`ifdef CONV_RELU_EN
    y_d = sat_d[O_BW-1] ? '0 : sat_d;
`else
    y_d = sat_d;
`endif
  end

  // Window update, sum register, output register: result appears two edges after acceptance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      done_reg      <= 1'b0;
      acc_valid_reg <= 1'b0;
      acc_reg       <= '0;
      o_y_valid     <= 1'b0;
      o_y           <= '0;
    end else begin
      done_reg      <= win_done;
      acc_valid_reg <= done_reg;
      if (done_reg) begin
        acc_reg <= sum_d;
      end
      o_y_valid <= acc_valid_reg;
      if (acc_valid_reg) begin
        o_y <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_kxk_stream.sv
// Directed bench for conv2d_kxk_stream at K=3, IMG_W=5: reset, frames, saturation, gaps, reload, RELU.
module tb_conv2d_kxk_stream;

  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int X_BW   = 8;
  localparam int W_BW   = 8;
  localparam int ACC_BW = 20;
  localparam int O_BW   = 16;

`ifdef CONV_RELU_EN
  localparam int RELU_EXP = 0;
`else
  localparam int RELU_EXP = -9;
`endif

  logic                   i_clk     = 1'b0;
  logic                   i_rst_n   = 1'b0;
  logic                   i_w_valid = 1'b0;
  logic signed [W_BW-1:0] i_w       = '0;
  logic                   i_sof     = 1'b0;
  logic                   i_x_valid = 1'b0;
  logic signed [X_BW-1:0] i_x       = '0;
  logic                   o_w_ready;
  logic                   o_y_valid;
  logic signed [O_BW-1:0] o_y;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int res_val[$];
  int res_cyc[$];
  int acc_edge[$];
  int exp_val[$];

  conv2d_kxk_stream #(
    .K(K), .IMG_W(IMG_W), .X_BW(X_BW), .W_BW(W_BW), .ACC_BW(ACC_BW), .O_BW(O_BW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_w_valid (i_w_valid),
    .i_w       (i_w),
    .o_w_ready (o_w_ready),
    .i_sof     (i_sof),
    .i_x_valid (i_x_valid),
    .i_x       (i_x),
    .o_y_valid (o_y_valid),
    .o_y       (o_y)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_y_valid) begin
      res_val.push_back(int'(o_y));
      res_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic wv, input int w, input logic xv, input int x, input logic sof);
    i_w_valid = wv;
    i_w       = W_BW'(w);
    i_x_valid = xv;
    i_x       = X_BW'(x);
    i_sof     = sof;
    @(posedge i_clk);
    #1;
    i_w_valid = 1'b0;
    i_x_valid = 1'b0;
    i_sof     = 1'b0;
  endtask

  // mode 1 loads w[i] = i, otherwise every weight equals val.
  task automatic load_weights(input int mode, input int val, input logic px, input string tag);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (mode == 1) ? i : val, px, 7, 1'b0);
      if (i == 0) check({tag, " ready low"}, int'(o_w_ready), 0);
    end
    check({tag, " ready high"}, int'(o_w_ready), 1);
    $display("[TB] %s: weights loaded, o_w_ready=%0d", tag, o_w_ready);
  endtask

  // mode 1 streams pixel(r,c) = 5r+c; with w[i]=i the window at (r,c) sums to 36*(5(r-2)+(c-2))+312.
  task automatic run_frame(input int mode, input int pval, input int gap, input logic use_sof,
                           input int expc, input string tag);
    int r;
    int c;
    int px;
    res_val.delete();
    res_cyc.delete();
    acc_edge.delete();
    exp_val.delete();
    for (int idx = 0; idx < 25; idx++) begin
      r  = idx / IMG_W;
      c  = idx % IMG_W;
      px = (mode == 1) ? (5 * r + c) : pval;
      step(1'b0, 0, 1'b1, px, use_sof && (idx == 0));
      if (r >= 2 && c >= 2) begin
        acc_edge.push_back(cyc);
        exp_val.push_back((mode == 1) ? (36 * (5 * (r - 2) + (c - 2)) + 312) : expc);
      end
      if (gap != 0) step(1'b0, 0, 1'b0, 99, 1'b0);
    end
    repeat (4) step(1'b0, 0, 1'b0, 0, 1'b0);
    check({tag, " count"}, res_val.size(), 9);
    for (int k = 0; k < 9 && k < res_val.size(); k++) begin
      $display("[TB] %s result %0d: y=%0d expected %0d, edge %0d (pixel edge %0d)",
               tag, k, res_val[k], exp_val[k], res_cyc[k], acc_edge[k]);
      check($sformatf("%s val%0d", tag, k), res_val[k], exp_val[k]);
      check($sformatf("%s lat%0d", tag, k), res_cyc[k] - acc_edge[k], 2);
    end
  endtask

  initial begin
    // Reset held with pixels presented.
    i_rst_n   = 1'b0;
    i_x_valid = 1'b1;
    i_x       = 8'sd5;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst y_valid", int'(o_y_valid), 0);
    check("rst y", int'(o_y), 0);
    check("rst w_ready", int'(o_w_ready), 0);
    $display("[TB] reset: o_y_valid=%0d o_y=%0d o_w_ready=%0d", o_y_valid, o_y, o_w_ready);
    i_rst_n   = 1'b1;
    i_x_valid = 1'b0;

    // Pixels before any weights are ignored.
    res_val.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b1, 1, i == 0);
    repeat (3) step(1'b0, 0, 1'b0, 0, 1'b0);
    check("noweights results", res_val.size(), 0);
    check("noweights w_ready", int'(o_w_ready), 0);

    load_weights(0, 1, 1'b0, "ones");
    run_frame(0, 1, 0, 1'b1, 9, "basic");
    check("basic hold y", int'(o_y), 9);
    check("basic idle valid", int'(o_y_valid), 0);

    run_frame(0, 1, 1, 1'b1, 9, "gaps");

    load_weights(0, 127, 1'b0, "w127");
    run_frame(0, 127, 0, 1'b1, 32767, "sat_pos");

    load_weights(0, -128, 1'b0, "wm128");
    run_frame(0, 127, 0, 1'b1, -32768, "sat_neg");

    // Reload mid-frame with pixels offered during the load; the next frame has no sof.
    load_weights(0, 1, 1'b0, "ones2");
    res_val.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 3, i == 0);
    load_weights(1, 0, 1'b1, "reload");
    check("reload no result", res_val.size(), 0);
    run_frame(1, 0, 0, 1'b0, 0, "ramp_nosof");

    // Weight and pixel together in RUN: weight wins, pixel dropped.
    res_val.delete();
    step(1'b1, 0, 1'b1, 50, 1'b0);
    check("drop ready low", int'(o_w_ready), 0);
    for (int i = 1; i < 9; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    check("drop ready high", int'(o_w_ready), 1);
    check("drop no result", res_val.size(), 0);
    run_frame(1, 0, 0, 1'b0, 0, "ramp_drop");

    // Reset right after the completing pixel discards the in-flight result.
    res_val.delete();
    for (int i = 0; i < 13; i++) step(1'b0, 0, 1'b1, 2, i == 0);
    i_rst_n = 1'b0;
    repeat (2) step(1'b0, 0, 1'b0, 0, 1'b0);
    i_rst_n = 1'b1;
    repeat (4) step(1'b0, 0, 1'b0, 0, 1'b0);
    check("midrst no result", res_val.size(), 0);
    check("midrst w_ready", int'(o_w_ready), 0);
    check("midrst y", int'(o_y), 0);
    $display("[TB] midrst: %0d results after reset", res_val.size());

    load_weights(0, -1, 1'b0, "wm1");
    run_frame(0, 1, 0, 1'b1, RELU_EXP, "relu");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
